reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/omicron_pkg.sv | 13 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/reg_writeback.sv | 108 ++++++++++
 tb/tb_reg_writeback.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/omicron_pkg.sv
// Shared widths and the pending-write entry type used by the writeback slice.
package omicron_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'b0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write queue; exposes its storage and per-slot valid bits
// so the parent can search queued entries for operand bypass.
module wb_fifo
  import omicron_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk_n,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic [PTR_W-1:0]      rd_ptr
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is cleared on reset so the head port reads zero while held in reset.
  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr]   <= push_entry;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign entries = mem;

endmodule

// File: rtl/reg_writeback.sv
// Register writeback: arbitrates load/ALU results into a pending-write queue,
// drains it to the register file, and optionally bypasses (OMICRON_WB_BYPASS_EN).
module reg_writeback
  import omicron_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk_n,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  input  logic                  wb_stall,
  output logic                  wea,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic                  fwd1_hit,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd2_data,
  output logic                  busy
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  wb_entry_t             push_entry;
  wb_entry_t             fifo_head;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic [PTR_W-1:0]      fifo_rd_ptr;
  logic                  mem_fire;
  logic                  alu_fire;

  // Loads win arbitration; readies are held low while in reset.
  assign mem_ready = rst_n & ~fifo_full;
  assign alu_ready = rst_n & ~fifo_full & ~mem_valid;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;

  // Writes to $0 complete the handshake but never occupy a slot.
  assign push_entry = mem_fire ? wb_entry_t'{addr: mem_addr, data: mem_data}
                               : wb_entry_t'{addr: alu_addr, data: alu_data};
  assign fifo_push  = (mem_fire & (mem_addr != REG_ZERO)) |
                      (alu_fire & (alu_addr != REG_ZERO));

  assign wea   = ~fifo_empty & ~wb_stall;
  assign waddr = fifo_head.addr;
  assign wdata = fifo_head.data;
  assign busy  = ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_n      (clk_n),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (wea),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .entries    (fifo_entries),
    .valid      (fifo_valid),
    .rd_ptr     (fifo_rd_ptr)
  );

`ifdef OMICRON_WB_BYPASS_EN
  logic [PTR_W-1:0] scan_idx;

  // Walk oldest to youngest from the read pointer so the youngest match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = fifo_rd_ptr + PTR_W'(i);
      if (fifo_valid[scan_idx] && (raddr1 != REG_ZERO) &&
          (fifo_entries[scan_idx].addr == raddr1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = fifo_entries[scan_idx].data;
      end
      if (fifo_valid[scan_idx] && (raddr2 != REG_ZERO) &&
          (fifo_entries[scan_idx].addr == raddr2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = fifo_entries[scan_idx].data;
      end
    end
  end
`else
  logic bypass_unused;

  assign fwd1_hit      = 1'b0;
  assign fwd1_data     = '0;
  assign fwd2_hit      = 1'b0;
  assign fwd2_data     = '0;
  assign bypass_unused = ^{raddr1, raddr2, fifo_entries, fifo_valid, fifo_rd_ptr};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed plus random stimulus for reg_writeback, checked against a queue model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk_n = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_addr = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic        wb_stall = 1'b0;
  logic        wea;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr1 = '0;
  logic [2:0]  raddr2 = '0;
  logic        fwd1_hit;
  logic [15:0] fwd1_data;
  logic        fwd2_hit;
  logic [15:0] fwd2_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  q_addr[$];
  logic [15:0] q_data[$];

  always #5 clk_n = ~clk_n;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk_n     (clk_n),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wb_stall  (wb_stall),
    .wea       (wea),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Youngest queued write to a nonzero register address, else no hit.
  task automatic model_lookup(input logic [2:0] ra, output logic hit, output logic [15:0] data);
    hit  = 1'b0;
    data = 16'h0000;
    if (ra != 3'd0) begin
      for (int i = q_addr.size() - 1; i >= 0; i--) begin
        if (q_addr[i] == ra) begin
          hit  = 1'b1;
          data = q_data[i];
          break;
        end
      end
    end
  endtask

  task automatic check_output();
    logic        e_hit1, e_hit2;
    logic [15:0] e_dat1, e_dat2;
    int          sz;
    sz = q_addr.size();
    if (!rst_n) begin
      chk("rst_wea", wea, 0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_fwd", {fwd1_hit, fwd2_hit, fwd1_data, fwd2_data}, 0);
      return;
    end
    chk("mem_ready", mem_ready, sz < DEPTH);
    chk("alu_ready", alu_ready, (sz < DEPTH) && !mem_valid);
    chk("busy", busy, sz > 0);
    chk("wea", wea, (sz > 0) && !wb_stall);
    if (sz > 0 && !wb_stall) begin
      chk("waddr", waddr, q_addr[0]);
      chk("wdata", wdata, q_data[0]);
    end
`ifdef OMICRON_WB_BYPASS_EN
    model_lookup(raddr1, e_hit1, e_dat1);
    model_lookup(raddr2, e_hit2, e_dat2);
`else
    e_hit1 = 1'b0; e_dat1 = 16'h0;
    e_hit2 = 1'b0; e_dat2 = 16'h0;
`endif
    chk("fwd1_hit", fwd1_hit, e_hit1);
    chk("fwd1_data", fwd1_data, e_dat1);
    chk("fwd2_hit", fwd2_hit, e_hit2);
    chk("fwd2_data", fwd2_data, e_dat2);
  endtask

  // One clock: check before the edge, then advance the model across it.
  task automatic apply_stimulus();
    bit pop_e, mem_acc, alu_acc;
    @(negedge clk_n);
    check_output();
    pop_e   = rst_n && (q_addr.size() > 0) && !wb_stall;
    mem_acc = rst_n && mem_valid && (q_addr.size() < DEPTH);
    alu_acc = rst_n && alu_valid && (q_addr.size() < DEPTH) && !mem_valid;
    @(posedge clk_n);
    if (pop_e) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (mem_acc && mem_addr != 3'd0) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_data);
    end else if (alu_acc && alu_addr != 3'd0) begin
      q_addr.push_back(alu_addr);
      q_data.push_back(alu_data);
    end
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [2:0] a, input logic [15:0] d);
    alu_valid = v; alu_addr = a; alu_data = d;
  endtask

  task automatic set_mem(input logic v, input logic [2:0] a, input logic [15:0] d);
    mem_valid = v; mem_addr = a; mem_data = d;
  endtask

  // Drops reset mid-cycle, checks the asynchronous clear, holds, releases.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    q_addr.delete();
    q_data.delete();
    #1 check_output();
    @(posedge clk_n);
    #1 check_output();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1 check_output();
    #12 rst_n = 1'b1;
    @(posedge clk_n); #1;
    apply_stimulus();

    // Single ALU write drains one cycle later for exactly one cycle.
    set_alu(1, 3'd3, 16'h1234);
    apply_stimulus();
    set_alu(0, 3'd0, 16'h0);
    apply_stimulus();
    apply_stimulus();

    // Load has priority over a simultaneous ALU request.
    set_mem(1, 3'd2, 16'hAAAA);
    set_alu(1, 3'd5, 16'h5555);
    apply_stimulus();
    set_mem(0, 3'd0, 16'h0);
    apply_stimulus();
    set_alu(0, 3'd0, 16'h0);
    apply_stimulus();
    apply_stimulus();

    // Writes to $0 handshake but never queue.
    set_alu(1, 3'd0, 16'hFFFF);
    apply_stimulus();
    set_alu(0, 3'd0, 16'h0);
    apply_stimulus();

    // Fill under stall, fifth request refused, then drain in order.
    wb_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_alu(1, 3'(k + 1), 16'(16'h1000 + k));
      apply_stimulus();
    end
    set_alu(0, 3'd0, 16'h0);
    apply_stimulus();
    wb_stall = 1'b0;
    for (int k = 0; k < 5; k++) apply_stimulus();

    // Bypass returns the youngest of two writes to the same register.
    wb_stall = 1'b1;
    set_alu(1, 3'd4, 16'h0001);
    apply_stimulus();
    set_alu(1, 3'd4, 16'h0002);
    apply_stimulus();
    set_alu(0, 3'd0, 16'h0);
    raddr1 = 3'd4;
    raddr2 = 3'd0;
    apply_stimulus();
    raddr2 = 3'd4;
    apply_stimulus();
    wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) apply_stimulus();

    // Reset mid-drain discards pending writes.
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_alu(1, 3'(k + 1), 16'(16'hBEE0 + k));
      apply_stimulus();
    end
    set_alu(0, 3'd0, 16'h0);
    pulse_reset();
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) apply_stimulus();

    // Random traffic against the queue model.
    for (int k = 0; k < 300; k++) begin
      set_mem($urandom_range(0, 3) == 0, 3'($urandom), 16'($urandom));
      set_alu($urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom));
      wb_stall = ($urandom_range(0, 3) == 0);
      raddr1   = 3'($urandom);
      raddr2   = 3'($urandom);
      apply_stimulus();
    end
    set_mem(0, 3'd0, 16'h0);
    set_alu(0, 3'd0, 16'h0);
    wb_stall = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) apply_stimulus();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
